// File: rtl/alu_seq_if.sv
// Command and result handshake bundle for alu_seq.
// master = command issuer / result consumer, slave = alu_seq.
interface alu_seq_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_inst;
   logic [10:0] cmd_arg1;
   logic [10:0] cmd_arg2;
   logic        res_valid;
   logic        res_ready;
   logic [10:0] res_data;

   modport master (
      output cmd_valid, cmd_inst, cmd_arg1, cmd_arg2, res_ready,
      input  cmd_ready, res_valid, res_data
   );

   modport slave (
      input  cmd_valid, cmd_inst, cmd_arg1, cmd_arg2, res_ready,
      output cmd_ready, res_valid, res_data
   );
endinterface

// File: rtl/alu_seq.sv
// Accumulator sequencer in front of an external combinational ALU.
// One command at a time: IDLE -> EXEC (1 or MUL_CYC cycles) -> RESP.
// The accumulator and result register update on the last EXEC edge.
module alu_seq #(
   parameter int MUL_CYC = 2
) (
   input  logic        clk,
   input  logic        rst,
   alu_seq_if.slave    bus,
   input  logic        acc_clr,
   output logic [3:0]  alu_inst,
   output logic [10:0] alu_arg1,
   output logic [10:0] alu_arg2,
   output logic [10:0] alu_acc,
   input  logic [10:0] alu_out,
   output logic [10:0] acc,
   output logic        busy,
   output logic [7:0]  op_count
);

   localparam int CW = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  alu_inst_q, alu_inst_d;
   logic [10:0] alu_arg1_q, alu_arg1_d;
   logic [10:0] alu_arg2_q, alu_arg2_d;
   logic [10:0] alu_acc_q, alu_acc_d;
   logic [10:0] acc_q, acc_d;
   logic [10:0] res_data_q, res_data_d;
   logic [7:0]  op_count_q, op_count_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        cmd_ready;
   logic        accept;
   logic [10:0] commit_val;

   // Ready only when idle and no clear pending; held low through reset.
   always_comb begin
      cmd_ready = (state_q == IDLE) && !acc_clr && !rst;
      accept    = bus.cmd_valid && cmd_ready;
   end

   // Value the accumulator takes at commit: ALU result, bypass for LDA, else hold.
   always_comb begin
      commit_val = acc_q;
      if (alu_inst_q inside {4'd5, 4'd6, 4'd7, 4'd8})
         commit_val = alu_out;
      else if (alu_inst_q == 4'd1)
         commit_val = alu_arg1_q;
   end

   // Next-state and register updates; everything holds unless the state acts on it.
   always_comb begin
      state_d    = state_q;
      alu_inst_d = alu_inst_q;
      alu_arg1_d = alu_arg1_q;
      alu_arg2_d = alu_arg2_q;
      alu_acc_d  = alu_acc_q;
      acc_d      = acc_q;
      res_data_d = res_data_q;
      op_count_d = op_count_q;
      cnt_d      = cnt_q;
      case (state_q)
         IDLE: begin
            if (acc_clr) begin
               acc_d = '0;
            end else if (accept) begin
               alu_inst_d = bus.cmd_inst;
               alu_arg1_d = bus.cmd_arg1;
               alu_arg2_d = bus.cmd_arg2;
               alu_acc_d  = acc_q;
               cnt_d      = (bus.cmd_inst == 4'd7) ? CW'(MUL_CYC - 1) : '0;
               state_d    = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == '0) begin
               acc_d      = commit_val;
               res_data_d = commit_val;
               op_count_d = op_count_q + 8'd1;
               state_d    = RESP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RESP: begin
            if (bus.res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset wins over any in-flight command.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         alu_inst_q <= '0;
         alu_arg1_q <= '0;
         alu_arg2_q <= '0;
         alu_acc_q  <= '0;
         acc_q      <= '0;
         res_data_q <= '0;
         op_count_q <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         alu_inst_q <= alu_inst_d;
         alu_arg1_q <= alu_arg1_d;
         alu_arg2_q <= alu_arg2_d;
         alu_acc_q  <= alu_acc_d;
         acc_q      <= acc_d;
         res_data_q <= res_data_d;
         op_count_q <= op_count_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.cmd_ready = cmd_ready;
   assign bus.res_valid = (state_q == RESP);
   assign bus.res_data  = res_data_q;
   assign alu_inst      = alu_inst_q;
   assign alu_arg1      = alu_arg1_q;
   assign alu_arg2      = alu_arg2_q;
   assign alu_acc       = alu_acc_q;
   assign acc           = acc_q;
   assign busy          = (state_q != IDLE);
   assign op_count      = op_count_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: transaction-level model + per-cycle compare,
// directed command sequences with hand-computed results.
module tb_alu_seq;
   localparam int MUL_CYC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        acc_clr;
   logic [3:0]  alu_inst;
   logic [10:0] alu_arg1, alu_arg2, alu_acc, alu_out, acc;
   logic        busy;
   logic [7:0]  op_count;

   alu_seq_if bus();

   alu_seq #(.MUL_CYC(MUL_CYC)) dut (
      .clk(clk), .rst(rst), .bus(bus), .acc_clr(acc_clr),
      .alu_inst(alu_inst), .alu_arg1(alu_arg1), .alu_arg2(alu_arg2),
      .alu_acc(alu_acc), .alu_out(alu_out), .acc(acc), .busy(busy),
      .op_count(op_count)
   );

   always #5 clk = ~clk;

   // External ALU: only the arithmetic opcodes produce a result.
   always_comb begin
      case (alu_inst)
         4'd5:    alu_out = alu_acc + alu_arg1;
         4'd6:    alu_out = alu_acc - alu_arg1;
         4'd7:    alu_out = alu_acc * alu_arg1;
         4'd8:    alu_out = ~alu_acc;
         default: alu_out = '0;
      endcase
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural result of a command given the accumulator at accept.
   function automatic logic [10:0] model_res(input logic [3:0] i, input logic [10:0] a1,
                                             input logic [10:0] a);
      case (i)
         4'd1:    return a1;
         4'd5:    return a + a1;
         4'd6:    return a - a1;
         4'd7:    return a * a1;
         4'd8:    return ~a;
         default: return a;
      endcase
   endfunction

   // Model: per accepted command, the cycle the response appears is
   // accept cycle + 1 + exec length; the result lands one cycle earlier.
   bit          m_started = 1'b0;
   bit          m_idle;
   int          m_cyc = 0;
   int          m_resp_from;
   logic [10:0] m_acc, m_res, m_pend, m_a1, m_a2, m_aacc;
   logic [3:0]  m_inst;
   logic [7:0]  m_cnt;

   always @(posedge clk) begin
      m_cyc     <= m_cyc + 1;
      m_started <= 1'b1;
      if (rst) begin
         m_idle <= 1'b1; m_acc <= '0; m_res <= '0; m_cnt <= '0;
         m_inst <= '0; m_a1 <= '0; m_a2 <= '0; m_aacc <= '0;
         m_resp_from <= 0;
      end else if (m_idle) begin
         if (acc_clr) begin
            m_acc <= '0;
         end else if (bus.cmd_valid) begin
            m_idle      <= 1'b0;
            m_inst      <= bus.cmd_inst;
            m_a1        <= bus.cmd_arg1;
            m_a2        <= bus.cmd_arg2;
            m_aacc      <= m_acc;
            m_pend      <= model_res(bus.cmd_inst, bus.cmd_arg1, m_acc);
            m_resp_from <= m_cyc + 1 + ((bus.cmd_inst == 4'd7) ? MUL_CYC : 1);
         end
      end else if (m_cyc == m_resp_from - 1) begin
         m_acc <= m_pend;
         m_res <= m_pend;
         m_cnt <= m_cnt + 8'd1;
      end else if (m_cyc >= m_resp_from && bus.res_ready) begin
         m_idle <= 1'b1;
      end
   end

   // Compare every output against the model each cycle.
   always @(negedge clk) begin
      if (m_started) begin
         chk("cmd_ready", 32'(bus.cmd_ready), 32'(m_idle && !acc_clr && !rst));
         chk("busy",      32'(busy),          32'(!m_idle));
         chk("res_valid", 32'(bus.res_valid), 32'(!m_idle && (m_cyc >= m_resp_from)));
         chk("res_data",  32'(bus.res_data),  32'(m_res));
         chk("acc",       32'(acc),           32'(m_acc));
         chk("op_count",  32'(op_count),      32'(m_cnt));
         chk("alu_inst",  32'(alu_inst),      32'(m_inst));
         chk("alu_arg1",  32'(alu_arg1),      32'(m_a1));
         chk("alu_arg2",  32'(alu_arg2),      32'(m_a2));
         chk("alu_acc",   32'(alu_acc),       32'(m_aacc));
      end
   end

   // Offer a command until accepted; returns #1 after the accept edge.
   task automatic send(input logic [3:0] i, input logic [10:0] a1, input logic [10:0] a2);
      bit ok;
      bus.cmd_valid = 1'b1; bus.cmd_inst = i; bus.cmd_arg1 = a1; bus.cmd_arg2 = a2;
      ok = 1'b0;
      for (int n = 0; n < 20 && !ok; n++) begin
         @(negedge clk);
         ok = bus.cmd_ready;
         @(posedge clk); #1;
      end
      chk("accept", 32'(ok), 32'd1);
      bus.cmd_valid = 1'b0;
      bus.cmd_inst  = 4'd5;
      bus.cmd_arg1  = 11'h7FF;
      bus.cmd_arg2  = 11'h555;
   endtask

   // Full command: accept, measure latency, optional backpressure, handshake.
   task automatic run_cmd(input logic [3:0] i, input logic [10:0] a1, input logic [10:0] exp_res,
                          input int lat, input int hold, input bit clr_exec);
      int n;
      send(i, a1, 11'd3);
      if (clr_exec) acc_clr = 1'b1;
      n = 1;
      while (!bus.res_valid && n < 20) begin
         @(posedge clk); #1;
         acc_clr = 1'b0;
         n++;
      end
      acc_clr = 1'b0;
      chk("latency", 32'(n), 32'(lat));
      chk("res_lit", 32'(bus.res_data), 32'(exp_res));
      for (int k = 0; k < hold; k++) begin
         bus.cmd_valid = 1'b1; bus.cmd_inst = 4'd5; bus.cmd_arg1 = 11'd1;
         @(posedge clk); #1;
         chk("hold_valid", 32'(bus.res_valid), 32'd1);
         chk("hold_data",  32'(bus.res_data),  32'(exp_res));
         chk("hold_busy",  32'(busy),          32'd1);
      end
      bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; acc_clr = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_inst = '0; bus.cmd_arg1 = '0; bus.cmd_arg2 = '0;
      bus.res_ready = 1'b0;
      @(posedge clk); #1;
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; #1;
      chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
      chk("post_rst_acc",   32'(acc),           32'd0);
      chk("post_rst_cnt",   32'(op_count),      32'd0);
      chk("post_rst_inst",  32'(alu_inst),      32'd0);

      // LDA 100, ADD 27
      run_cmd(4'd1, 11'd100, 11'd100, 2, 0, 1'b0);
      run_cmd(4'd5, 11'd27,  11'd127, 2, 0, 1'b0);
      chk("op_count_2", 32'(op_count), 32'd2);
      // SUB 200 wraps to 1975, NOT gives 72
      run_cmd(4'd6, 11'd200, 11'd1975, 2, 0, 1'b0);
      run_cmd(4'd8, 11'd0,   11'd72,   2, 0, 1'b0);
      // 64 * 32 = 2048 wraps to 0, three-cycle latency
      run_cmd(4'd1, 11'd64,  11'd64, 2, 0, 1'b0);
      run_cmd(4'd7, 11'd32,  11'd0,  3, 0, 1'b0);
      // Backpressure five cycles with a command offered throughout
      run_cmd(4'd1, 11'd5,   11'd5,  2, 5, 1'b0);
      chk("bp_acc", 32'(acc), 32'd5);
      // Clear in IDLE with a command offered: cleared, not accepted
      acc_clr = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_inst = 4'd5; bus.cmd_arg1 = 11'd3;
      @(posedge clk); #1;
      chk("clr_acc",  32'(acc),  32'd0);
      chk("clr_busy", 32'(busy), 32'd0);
      acc_clr = 1'b0; bus.cmd_valid = 1'b0;
      // Clear pulsed during EXEC is ignored
      run_cmd(4'd1, 11'd10, 11'd10, 2, 0, 1'b0);
      run_cmd(4'd5, 11'd5,  11'd15, 2, 0, 1'b1);
      chk("clr_exec_acc", 32'(acc), 32'd15);
      // Reset in the first EXEC cycle of a MUL
      run_cmd(4'd1, 11'd64, 11'd64, 2, 0, 1'b0);
      send(4'd7, 11'd32, 11'd9);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; #1;
      chk("mrst_busy",  32'(busy),          32'd0);
      chk("mrst_valid", 32'(bus.res_valid), 32'd0);
      chk("mrst_cnt",   32'(op_count),      32'd0);
      chk("mrst_acc",   32'(acc),           32'd0);
      chk("mrst_inst",  32'(alu_inst),      32'd0);
      chk("mrst_arg1",  32'(alu_arg1),      32'd0);
      chk("mrst_data",  32'(bus.res_data),  32'd0);
      repeat (4) @(posedge clk);
      #1;
      // op_count wraps 255 -> 0; NOP-class opcodes leave acc at 0
      for (int k = 0; k < 255; k++)
         run_cmd((k % 2 == 0) ? 4'd0 : 4'd3, 11'(k), 11'd0, 2, 0, 1'b0);
      chk("cnt_255", 32'(op_count), 32'd255);
      run_cmd(4'd2, 11'd9, 11'd0, 2, 0, 1'b0);
      chk("cnt_wrap", 32'(op_count), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
